// File: rtl/result_uart_tx_pkg.sv
// Shared types and constants for the adder-result UART transmitter.
package result_tx_pkg;
  localparam int   RES_W   = 5;
  localparam int   BYTE_W  = 8;
  localparam logic TX_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;
endpackage

// File: rtl/result_uart_tx_if.sv
// Valid/ready result handshake between the adder and the UART transmitter.
interface result_uart_tx_if;
  import result_tx_pkg::*;

  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             res_ready;

  modport master (output res_valid, output res_data, input  res_ready);
  modport slave  (input  res_valid, input  res_data, output res_ready);
endinterface

// File: rtl/result_uart_tx_fifo.sv
// Synchronous FIFO with write valid/ready, read valid/pop and occupancy count.
module result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr_valid,
  output logic                   o_wr_ready,
  input  logic [WIDTH-1:0]       i_wr_data,
  output logic                   o_rd_valid,
  input  logic                   i_rd_pop,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Full/empty come straight from the registered count.
  assign o_wr_ready = (r_count != CNT_W'(DEPTH));
  assign o_rd_valid = (r_count != '0);
  assign w_push     = i_wr_valid && o_wr_ready;
  assign w_pop      = i_rd_pop && o_rd_valid;
  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end
endmodule

// File: rtl/result_uart_tx.sv
// Buffers adder results and sends each as one UART byte {3'b000, result}.
// Define RESULT_TX_PARITY_EN for 8E1 framing; default build is 8N1.
//
// state     | meaning
// ST_IDLE   | line high, pops the FIFO when it holds an entry
// ST_START  | start bit (low)
// ST_DATA   | 8 data bits, LSB first
// ST_PARITY | even parity bit (parity build only)
// ST_STOP   | stop bit (high)
module result_uart_tx
  import result_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  result_uart_tx_if.slave             bus,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t         r_state, w_state_nxt;
  logic [BAUD_W-1:0] r_baud, w_baud_nxt;
  logic [2:0]        r_bit_idx, w_bit_idx_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_baud_done;
  logic              w_fifo_valid;
  logic              w_pop;
  logic [RES_W-1:0]  w_fifo_data;
`ifdef RESULT_TX_PARITY_EN
  logic              r_parity, w_parity_nxt;
`endif

  result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_valid (bus.res_valid),
    .o_wr_ready (bus.res_ready),
    .i_wr_data  (bus.res_data),
    .o_rd_valid (w_fifo_valid),
    .i_rd_pop   (w_pop),
    .o_rd_data  (w_fifo_data),
    .o_count    (fifo_count)
  );

  assign w_baud_done = (r_baud == BAUD_LAST);
  assign tx          = r_tx;
  assign tx_busy     = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = TX_IDLE;
    w_pop         = 1'b0;
`ifdef RESULT_TX_PARITY_EN
    w_parity_nxt  = r_parity;
`endif
    if (r_state == ST_IDLE || w_baud_done) w_baud_nxt = '0;
    else                                   w_baud_nxt = r_baud + BAUD_W'(1);

    // The pin flop follows the current state, so tx trails the FSM by one cycle.
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_valid) begin
          w_pop         = 1'b1;
          w_state_nxt   = ST_START;
          w_shift_nxt   = {{(BYTE_W - RES_W){1'b0}}, w_fifo_data};
          w_bit_idx_nxt = '0;
`ifdef RESULT_TX_PARITY_EN
          w_parity_nxt  = ^w_fifo_data;
`endif
        end
      end
      ST_START: begin
        w_tx_nxt = 1'b0;
        if (w_baud_done) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_tx_nxt = r_shift[0];
        if (w_baud_done) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_idx == 3'd7) begin
`ifdef RESULT_TX_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
`ifdef RESULT_TX_PARITY_EN
      ST_PARITY: begin
        w_tx_nxt = r_parity;
        if (w_baud_done) w_state_nxt = ST_STOP;
      end
`endif
      ST_STOP: begin
        w_tx_nxt = TX_IDLE;
        if (w_baud_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= TX_IDLE;
`ifdef RESULT_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
`ifdef RESULT_TX_PARITY_EN
      r_parity  <= w_parity_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// Directed self-checking bench for result_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_result_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         busy_run = 0;
  int         last_run = 0;

  result_uart_tx_if u_if ();

  result_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (u_if),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Length of the most recent busy stretch, used for frame-length checks.
  always @(negedge clk) begin
    if (rst) busy_run = 0;
    else if (tx_busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tx_low(input int max);
    int c = 0;
    while (tx !== 1'b0 && c < max) begin
      @(negedge clk);
      c++;
    end
    chk("start_wait", 32'(tx), 32'd0);
  endtask

  // Entered on the first negedge where tx is low; leaves one cycle after the idle gap.
  task automatic rx_frame(input logic [7:0] exp, input string tag, input bit more,
                          input bit do_push, input logic [4:0] push_data);
    logic [7:0] b;
    b = '0;
    step(2);
    chk({tag, "_start"}, 32'(tx), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(4);
      b[i] = tx;
    end
`ifdef RESULT_TX_PARITY_EN
    step(4);
    chk({tag, "_parity"}, 32'(tx), 32'(^exp));
`endif
    step(4);
    chk({tag, "_stop"}, 32'(tx), 32'd1);
    step(1);
    chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_idle_tx"}, 32'(tx), 32'd1);
    if (do_push) begin
      chk({tag, "_pp_count_pre"}, 32'(fifo_count), 32'd2);
      u_if.res_valid = 1'b1;
      u_if.res_data  = push_data;
    end
    step(1);
    if (do_push) begin
      u_if.res_valid = 1'b0;
      chk({tag, "_pp_count"}, 32'(fifo_count), 32'd2);
    end
    chk({tag, "_next_busy"}, 32'(tx_busy), 32'(more));
    chk({tag, "_gap_tx"}, 32'(tx), 32'd1);
    step(1);
    chk({tag, "_next_tx"}, 32'(tx), more ? 32'd0 : 32'd1);
    chk({tag, "_byte"}, 32'(b), 32'(exp));
  endtask

  logic [4:0] full_vals [6] = '{5'h11, 5'h02, 5'h1B, 5'h04, 5'h1D, 5'h16};

  initial begin
    bit seen_low;
    u_if.res_valid = 1'b0;
    u_if.res_data  = '0;

    // reset values
    rst = 1'b1;
    step(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(u_if.res_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    rst = 1'b0;
    step(2);

    // single result 5'h1F and latency
    u_if.res_valid = 1'b1;
    u_if.res_data  = 5'h1F;
    step(1);
    u_if.res_valid = 1'b0;
    chk("lat_count_n", 32'(fifo_count), 32'd1);
    chk("lat_tx_n", 32'(tx), 32'd1);
    step(1);
    chk("lat_busy_n1", 32'(tx_busy), 32'd1);
    chk("lat_tx_n1", 32'(tx), 32'd1);
    chk("lat_count_n1", 32'(fifo_count), 32'd0);
    step(1);
    chk("lat_tx_n2", 32'(tx), 32'd0);
    rx_frame(8'h1F, "single", 1'b0, 1'b0, 5'h00);
    chk("single_frame_len", 32'(last_run), 32'(FRAME));

    // 5'h07: parity 1 in the parity build
    u_if.res_valid = 1'b1;
    u_if.res_data  = 5'h07;
    step(1);
    u_if.res_valid = 1'b0;
    step(2);
    chk("p07_tx_fall", 32'(tx), 32'd0);
    rx_frame(8'h07, "p07", 1'b0, 1'b0, 5'h00);
    chk("p07_frame_len", 32'(last_run), 32'(FRAME));

    // back-to-back
    u_if.res_valid = 1'b1;
    u_if.res_data  = 5'h00;
    step(1);
    u_if.res_data  = 5'h10;
    step(1);
    u_if.res_data  = 5'h0A;
    step(1);
    u_if.res_valid = 1'b0;
    chk("b2b_count", 32'(fifo_count), 32'd2);
    chk("b2b_tx_fall", 32'(tx), 32'd0);
    rx_frame(8'h00, "b2b0", 1'b1, 1'b0, 5'h00);
    rx_frame(8'h10, "b2b1", 1'b1, 1'b0, 5'h00);
    rx_frame(8'h0A, "b2b2", 1'b0, 1'b0, 5'h00);

    // push coinciding with pop at occupancy 2
    u_if.res_valid = 1'b1;
    u_if.res_data  = 5'h03;
    step(1);
    u_if.res_data  = 5'h0C;
    step(1);
    u_if.res_data  = 5'h15;
    step(1);
    u_if.res_valid = 1'b0;
    chk("pp_count_start", 32'(fifo_count), 32'd2);
    rx_frame(8'h03, "pp0", 1'b1, 1'b1, 5'h1E);
    rx_frame(8'h0C, "pp1", 1'b1, 1'b0, 5'h00);
    rx_frame(8'h15, "pp2", 1'b1, 1'b0, 5'h00);
    rx_frame(8'h1E, "pp3", 1'b0, 1'b0, 5'h00);

    // full FIFO with res_valid held
    fork
      begin : driver
        int  idx = 0;
        int  cyc = 0;
        logic acc;
        u_if.res_valid = 1'b1;
        u_if.res_data  = full_vals[0];
        while (idx < 6 && cyc < 400) begin
          acc = u_if.res_ready;
          @(negedge clk);
          cyc++;
          if (acc) begin
            idx++;
            if (idx == 4) chk("full_ready_at4", 32'(u_if.res_ready), 32'd1);
            if (idx == 5) begin
              chk("full_ready_at5", 32'(u_if.res_ready), 32'd0);
              chk("full_count_at5", 32'(fifo_count), 32'd4);
            end
            if (idx < 6) u_if.res_data = full_vals[idx];
            else         u_if.res_valid = 1'b0;
          end
        end
        u_if.res_valid = 1'b0;
        chk("full_accepts", 32'(idx), 32'd6);
      end
      begin : receiver
        wait_tx_low(20);
        for (int i = 0; i < 6; i++)
          rx_frame({3'b000, full_vals[i]}, $sformatf("full%0d", i), (i < 5), 1'b0, 5'h00);
      end
    join

    // reset mid-frame
    u_if.res_valid = 1'b1;
    u_if.res_data  = 5'h19;
    step(1);
    u_if.res_data  = 5'h06;
    step(1);
    u_if.res_valid = 1'b0;
    wait_tx_low(10);
    step(10);
    chk("mid_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b1;
    step(1);
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready", 32'(u_if.res_ready), 32'd1);
    step(2);
    rst = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      step(1);
      if (tx !== 1'b1 || tx_busy !== 1'b0) seen_low = 1'b1;
    end
    chk("mid_no_tail", 32'(seen_low), 32'd0);
    chk("mid_count_post", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
